// File: rtl/ddr_rr_sched_pkg.sv
// Shared defaults, FIFO operation encoding and round-robin index helpers for ddr_rr_sched.
package ddr_rr_sched_pkg;

    localparam int DDR_ARBT_NUM  = 2;
    localparam int DDR_ARBT_DEEP = 4;

    typedef enum logic [1:0] {
        FIFO_IDLE = 2'b00,
        FIFO_PUSH = 2'b01,
        FIFO_POP  = 2'b10,
        FIFO_BOTH = 2'b11
    } fifo_op_e;

    function automatic int rr_add(input int p, input int k, input int n);
        return (p + k) % n;
    endfunction

endpackage

// File: rtl/ddr_arbt_idx_fifo.sv
// In-order FIFO of granted requester indices; registered count with full/empty flags.
module ddr_arbt_idx_fifo
    import ddr_rr_sched_pkg::*;
#(
    parameter int W  = 1,
    parameter int DP = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);
    localparam int PW = (DP > 1) ? $clog2(DP) : 1;
    localparam int CW = $clog2(DP + 1);

    logic [W-1:0]  mem [DP];
    logic [PW-1:0] rd_ptr, wr_ptr;
    logic [CW-1:0] cnt;
    fifo_op_e      op;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DP - 1)) ? '0 : p + PW'(1);
    endfunction

    assign op    = fifo_op_e'({pop, push});
    assign full  = (cnt == CW'(DP));
    assign empty = (cnt == '0);
    assign dout  = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
        end else begin
            case (op)
                FIFO_PUSH: begin
                    wr_ptr <= ptr_inc(wr_ptr);
                    cnt    <= cnt + CW'(1);
                end
                FIFO_POP: begin
                    rd_ptr <= ptr_inc(rd_ptr);
                    cnt    <= cnt - CW'(1);
                end
                FIFO_BOTH: begin
                    wr_ptr <= ptr_inc(wr_ptr);
                    rd_ptr <= ptr_inc(rd_ptr);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/ddr_rr_sched.sv
// Round-robin ICB scheduler sharing one MIG port among ARBT_NUM requesters, responses routed in order.
// Optional macro MYRISCV_DDR_ARBT_LOCK_EN: a lock=1 command gives its requester exclusive grant until lock=0.
module ddr_rr_sched
    import ddr_rr_sched_pkg::*;
#(
    parameter int ARBT_NUM = DDR_ARBT_NUM,
    parameter int AW       = 32,
    parameter int DW       = 32,
    parameter int FIFO_DP  = DDR_ARBT_DEEP
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [ARBT_NUM-1:0]        i_icb_cmd_vld,
    output logic [ARBT_NUM-1:0]        i_icb_cmd_rdy,
    input  logic [ARBT_NUM-1:0]        i_icb_cmd_read,
    input  logic [ARBT_NUM*AW-1:0]     i_icb_cmd_addr,
    input  logic [ARBT_NUM*DW-1:0]     i_icb_cmd_wdata,
    input  logic [ARBT_NUM*DW/8-1:0]   i_icb_cmd_wmask,
    input  logic [ARBT_NUM-1:0]        i_icb_cmd_lock,
    input  logic [ARBT_NUM*2-1:0]      i_icb_cmd_size,
    output logic [ARBT_NUM-1:0]        i_icb_rsp_vld,
    input  logic [ARBT_NUM-1:0]        i_icb_rsp_rdy,
    output logic [ARBT_NUM-1:0]        i_icb_rsp_err,
    output logic [ARBT_NUM*DW-1:0]     i_icb_rsp_rdata,
    output logic                       o_icb_cmd_vld,
    input  logic                       o_icb_cmd_rdy,
    output logic                       o_icb_cmd_read,
    output logic [AW-1:0]              o_icb_cmd_addr,
    output logic [DW-1:0]              o_icb_cmd_wdata,
    output logic [DW/8-1:0]            o_icb_cmd_wmask,
    output logic                       o_icb_cmd_lock,
    output logic [1:0]                 o_icb_cmd_size,
    input  logic                       o_icb_rsp_vld,
    output logic                       o_icb_rsp_rdy,
    input  logic                       o_icb_rsp_err,
    input  logic [DW-1:0]              o_icb_rsp_rdata
);
    localparam int IW = (ARBT_NUM > 1) ? $clog2(ARBT_NUM) : 1;
    localparam int MW = DW / 8;

    logic [IW-1:0]       rr_ptr, gnt_q, pick, gnt, head;
    logic                hold, pick_vld, gnt_act, keep_ptr;
    logic                fifo_full, fifo_empty, cmd_hs, rsp_hs;
    logic [ARBT_NUM-1:0] req_m;

`ifdef MYRISCV_DDR_ARBT_LOCK_EN
    logic          lock_own;
    logic [IW-1:0] lock_idx;

    always_comb begin
        req_m = i_icb_cmd_vld;
        if (lock_own) begin
            req_m           = '0;
            req_m[lock_idx] = i_icb_cmd_vld[lock_idx];
        end
    end

    // Pointer stays put while the granted requester is (still) holding the lock.
    assign keep_ptr = i_icb_cmd_lock[gnt];

    always_ff @(posedge clk) begin
        if (!rst) begin
            lock_own <= 1'b0;
            lock_idx <= '0;
        end else if (cmd_hs) begin
            lock_own <= i_icb_cmd_lock[gnt];
            lock_idx <= gnt;
        end
    end
`else
    assign req_m    = i_icb_cmd_vld;
    assign keep_ptr = 1'b0;
`endif

    always_comb begin
        int idx;
        pick     = rr_ptr;
        pick_vld = 1'b0;
        for (int k = ARBT_NUM - 1; k >= 0; k--) begin
            idx = rr_add(int'(rr_ptr), k, ARBT_NUM);
            if (req_m[idx]) begin
                pick     = IW'(idx);
                pick_vld = 1'b1;
            end
        end
    end

    // A stalled command keeps its grant so the MIG sees stable fields until it is accepted.
    assign gnt     = hold ? gnt_q : pick;
    assign gnt_act = rst && (hold || pick_vld);
    assign o_icb_cmd_vld = gnt_act && i_icb_cmd_vld[gnt] && !fifo_full;
    assign cmd_hs        = o_icb_cmd_vld && o_icb_cmd_rdy;

    always_comb begin
        i_icb_cmd_rdy      = '0;
        i_icb_cmd_rdy[gnt] = gnt_act && o_icb_cmd_rdy && !fifo_full;
    end

    assign o_icb_cmd_read  = i_icb_cmd_read[gnt];
    assign o_icb_cmd_addr  = i_icb_cmd_addr[int'(gnt)*AW +: AW];
    assign o_icb_cmd_wdata = i_icb_cmd_wdata[int'(gnt)*DW +: DW];
    assign o_icb_cmd_wmask = i_icb_cmd_wmask[int'(gnt)*MW +: MW];
    assign o_icb_cmd_lock  = i_icb_cmd_lock[gnt];
    assign o_icb_cmd_size  = i_icb_cmd_size[int'(gnt)*2 +: 2];

    always_ff @(posedge clk) begin
        if (!rst) begin
            rr_ptr <= '0;
            hold   <= 1'b0;
            gnt_q  <= '0;
        end else begin
            hold <= o_icb_cmd_vld && !o_icb_cmd_rdy;
            if (o_icb_cmd_vld && !o_icb_cmd_rdy)
                gnt_q <= gnt;
            if (cmd_hs && !keep_ptr)
                rr_ptr <= IW'(rr_add(int'(gnt), 1, ARBT_NUM));
        end
    end

    ddr_arbt_idx_fifo #(.W(IW), .DP(FIFO_DP)) u_idx_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (cmd_hs),
        .din   (gnt),
        .pop   (rsp_hs),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Responses only ever go to the oldest outstanding requester; an empty FIFO blocks the MIG.
    always_comb begin
        i_icb_rsp_vld       = '0;
        i_icb_rsp_vld[head] = rst && !fifo_empty && o_icb_rsp_vld;
    end

    assign o_icb_rsp_rdy   = rst && !fifo_empty && i_icb_rsp_rdy[head];
    assign rsp_hs          = o_icb_rsp_vld && o_icb_rsp_rdy;
    assign i_icb_rsp_err   = {ARBT_NUM{o_icb_rsp_err}};
    assign i_icb_rsp_rdata = {ARBT_NUM{o_icb_rsp_rdata}};

endmodule

// File: tb/tb_ddr_rr_sched.sv
// Self-checking bench for ddr_rr_sched (N=2, FIFO_DP=4): vector table, directed corner sequences, random vs. queue model.
module tb_ddr_rr_sched;
    localparam int N  = 2;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int DP = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [N-1:0]      c_vld = '0, c_rdy, c_read = '0, c_lock = '0;
    logic [N*AW-1:0]   c_addr = '0;
    logic [N*DW-1:0]   c_wdata = '0;
    logic [N*DW/8-1:0] c_wmask = '0;
    logic [N*2-1:0]    c_size = '0;
    logic [N-1:0]      r_vld, r_rdy = '0, r_err;
    logic [N*DW-1:0]   r_rdata;
    logic              m_vld, m_rdy = 1'b0, m_read, m_lock;
    logic [AW-1:0]     m_addr;
    logic [DW-1:0]     m_wdata;
    logic [DW/8-1:0]   m_wmask;
    logic [1:0]        m_size;
    logic              s_vld = 1'b0, s_rdy, s_err = 1'b0;
    logic [DW-1:0]     s_rdata = '0;

    int checks = 0;
    int errors = 0;

    ddr_rr_sched #(.ARBT_NUM(N), .AW(AW), .DW(DW), .FIFO_DP(DP)) dut (
        .clk(clk), .rst(rst),
        .i_icb_cmd_vld(c_vld), .i_icb_cmd_rdy(c_rdy), .i_icb_cmd_read(c_read),
        .i_icb_cmd_addr(c_addr), .i_icb_cmd_wdata(c_wdata), .i_icb_cmd_wmask(c_wmask),
        .i_icb_cmd_lock(c_lock), .i_icb_cmd_size(c_size),
        .i_icb_rsp_vld(r_vld), .i_icb_rsp_rdy(r_rdy), .i_icb_rsp_err(r_err), .i_icb_rsp_rdata(r_rdata),
        .o_icb_cmd_vld(m_vld), .o_icb_cmd_rdy(m_rdy), .o_icb_cmd_read(m_read), .o_icb_cmd_addr(m_addr),
        .o_icb_cmd_wdata(m_wdata), .o_icb_cmd_wmask(m_wmask), .o_icb_cmd_lock(m_lock), .o_icb_cmd_size(m_size),
        .o_icb_rsp_vld(s_vld), .o_icb_rsp_rdy(s_rdy), .o_icb_rsp_err(s_err), .o_icb_rsp_rdata(s_rdata)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        c_vld = '0; c_lock = '0; m_rdy = 1'b0; s_vld = 1'b0; r_rdy = '0; s_err = 1'b0;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
    endtask

    typedef struct {
        logic [1:0]  vld;
        logic        ordy;
        logic        rspv;
        logic [1:0]  rsprdy;
        logic        e_ovld;
        logic [1:0]  e_irdy;
        logic [31:0] e_addr;
        logic        e_read;
        logic        e_orsprdy;
        logic [1:0]  e_irspv;
    } vec_t;

    vec_t tbl[6];

    logic [1:0] rv = '0;
    int         m_ptr, m_pidx, g;
    bit         m_pend;
    int         m_q[$];
    logic       e_ovld, e_ordy;
    logic [1:0] e_irdy, e_rspv;
    logic [1:0] lock_exp[4];

    initial begin
        // vld ordy rspv rsprdy | ovld irdy addr read orsprdy irspv
        tbl[0] = '{2'b00, 1'b1, 1'b0, 2'b00, 1'b0, 2'b00, 32'h0,         1'b0, 1'b0, 2'b00};
        tbl[1] = '{2'b01, 1'b1, 1'b0, 2'b00, 1'b1, 2'b01, 32'h1000_0000, 1'b0, 1'b0, 2'b00};
        tbl[2] = '{2'b10, 1'b1, 1'b0, 2'b00, 1'b1, 2'b10, 32'h2000_0004, 1'b1, 1'b0, 2'b00};
        tbl[3] = '{2'b11, 1'b1, 1'b0, 2'b00, 1'b1, 2'b01, 32'h1000_0000, 1'b0, 1'b0, 2'b00};
        tbl[4] = '{2'b11, 1'b0, 1'b0, 2'b00, 1'b1, 2'b00, 32'h1000_0000, 1'b0, 1'b0, 2'b00};
        tbl[5] = '{2'b10, 1'b0, 1'b1, 2'b11, 1'b1, 2'b00, 32'h2000_0004, 1'b1, 1'b0, 2'b00};

        // Reset: all requesters valid, nothing may be granted while rst is low.
        c_vld = 2'b11; m_rdy = 1'b1; c_addr = {32'h2000_0004, 32'h1000_0000};
        for (int i = 0; i < 3; i++) begin
            step();
            chk("rst_ovld", 64'(m_vld), 64'd0);
            chk("rst_irdy", 64'(c_rdy), 64'd0);
            chk("rst_orsprdy", 64'(s_rdy), 64'd0);
        end
        rst = 1'b1;
        #1;
        chk("rst_first_gnt", 64'(c_rdy), 64'b01);
        chk("rst_first_addr", 64'(m_addr), 64'h1000_0000);
        c_vld = '0;
        do_reset();

        // Combinational vectors from the reset state (no clock edge in between).
        c_read = 2'b10;
        for (int i = 0; i < 6; i++) begin
            c_vld = tbl[i].vld; m_rdy = tbl[i].ordy; s_vld = tbl[i].rspv; r_rdy = tbl[i].rsprdy;
            #1;
            chk($sformatf("vec%0d_ovld", i), 64'(m_vld), 64'(tbl[i].e_ovld));
            chk($sformatf("vec%0d_irdy", i), 64'(c_rdy), 64'(tbl[i].e_irdy));
            chk($sformatf("vec%0d_orsprdy", i), 64'(s_rdy), 64'(tbl[i].e_orsprdy));
            chk($sformatf("vec%0d_irspv", i), 64'(r_vld), 64'(tbl[i].e_irspv));
            if (tbl[i].e_ovld) begin
                chk($sformatf("vec%0d_addr", i), 64'(m_addr), 64'(tbl[i].e_addr));
                chk($sformatf("vec%0d_read", i), 64'(m_read), 64'(tbl[i].e_read));
            end
        end
        idle();
        do_reset();

        // Round-robin fairness with responses two cycles behind.
        m_rdy = 1'b1; r_rdy = 2'b11;
        for (int c = 0; c < 6; c++) begin
            c_vld = (c < 4) ? 2'b11 : 2'b00;
            s_vld = (c >= 2);
            s_rdata = 32'hA0 + 32'(c);
            #1;
            if (c < 4) chk($sformatf("rr_gnt%0d", c), 64'(c_rdy), (c % 2) ? 64'b10 : 64'b01);
            if (c >= 2) begin
                chk($sformatf("rr_rsp%0d", c), 64'(r_vld), (c % 2) ? 64'b10 : 64'b01);
                chk($sformatf("rr_rdata%0d", c), 64'(r_rdata), {2{32'hA0 + 32'(c)}});
            end
            step();
        end
        do_reset();

        // Stalled grant must not be pre-empted by a higher-priority arrival.
        c_addr = {32'h8000_0010, 32'h1000_0000};
        for (int c = 0; c < 5; c++) begin
            c_vld = (c < 2) ? 2'b10 : (c < 4) ? 2'b11 : 2'b01;
            m_rdy = (c >= 3);
            #1;
            chk($sformatf("stall_ovld%0d", c), 64'(m_vld), 64'd1);
            chk($sformatf("stall_addr%0d", c), 64'(m_addr), (c < 4) ? 64'h8000_0010 : 64'h1000_0000);
            chk($sformatf("stall_irdy%0d", c), 64'(c_rdy), (c < 3) ? 64'b00 : (c == 3) ? 64'b10 : 64'b01);
            step();
        end
        do_reset();

        // FIFO full blocks the 5th command until one response pops.
        c_vld = 2'b01; m_rdy = 1'b1;
        for (int c = 0; c < 4; c++) begin
            #1 chk($sformatf("full_acc%0d", c), 64'(c_rdy), 64'b01);
            step();
        end
        #1;
        chk("full_ovld", 64'(m_vld), 64'd0);
        chk("full_irdy", 64'(c_rdy), 64'd0);
        step();
        s_vld = 1'b1; r_rdy = 2'b01;
        #1;
        chk("full_pop_rdy", 64'(s_rdy), 64'd1);
        chk("full_pop_ovld", 64'(m_vld), 64'd0);
        step();
        s_vld = 1'b0;
        #1;
        chk("full_5th_ovld", 64'(m_vld), 64'd1);
        chk("full_5th_irdy", 64'(c_rdy), 64'b01);
        idle();
        do_reset();

        // Response ordering and backpressure: outstanding order 1 then 0.
        m_rdy = 1'b1;
        c_vld = 2'b10; #1 chk("ord_gnt1", 64'(c_rdy), 64'b10); step();
        c_vld = 2'b01; #1 chk("ord_gnt0", 64'(c_rdy), 64'b01); step();
        c_vld = 2'b00; s_vld = 1'b1; s_rdata = 32'hDEAD_BEEF; r_rdy = 2'b01;
        for (int c = 0; c < 2; c++) begin
            #1;
            chk("ord_bp_orsprdy", 64'(s_rdy), 64'd0);
            chk("ord_bp_irspv", 64'(r_vld), 64'b10);
            step();
        end
        r_rdy = 2'b11; s_err = 1'b1;
        #1;
        chk("ord_rsp1_rdy", 64'(s_rdy), 64'd1);
        chk("ord_rsp1_vld", 64'(r_vld), 64'b10);
        chk("ord_rsp1_data", 64'(r_rdata[63:32]), 64'hDEAD_BEEF);
        chk("ord_err", 64'(r_err), 64'b11);
        step();
        s_err = 1'b0; s_rdata = 32'h1234_5678;
        #1;
        chk("ord_rsp0_vld", 64'(r_vld), 64'b01);
        chk("ord_rsp0_rdy", 64'(s_rdy), 64'd1);
        step();
        c_vld = 2'b01;
        #1;
        chk("ord_empty_rdy", 64'(s_rdy), 64'd0);
        chk("ord_empty_vld", 64'(r_vld), 64'b00);
        chk("ord_empty_cmd", 64'(c_rdy), 64'b01);
        idle();
        do_reset();

        // Lock: req0 locks twice then unlocks while req1 waits.
`ifdef MYRISCV_DDR_ARBT_LOCK_EN
        lock_exp = '{2'b01, 2'b01, 2'b01, 2'b10};
`else
        lock_exp = '{2'b01, 2'b10, 2'b01, 2'b10};
`endif
        c_vld = 2'b11; m_rdy = 1'b1;
        for (int c = 0; c < 4; c++) begin
            c_lock = (c < 2) ? 2'b01 : 2'b00;
            #1;
            chk($sformatf("lock_gnt%0d", c), 64'(c_rdy), 64'(lock_exp[c]));
            if (c == 0) chk("lock_fwd", 64'(m_lock), 64'd1);
            step();
        end
        idle();
        do_reset();

        // Random traffic against a queue-based model of the scheduling rules.
        m_ptr = 0; m_pend = 0; m_pidx = 0; m_q.delete(); rv = '0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            for (int i = 0; i < N; i++) begin
                if (!rv[i]) begin
                    rv[i] = 1'($urandom_range(0, 1));
                    c_addr[i*AW +: AW] = $urandom;
                    c_read[i] = 1'($urandom_range(0, 1));
                end
            end
            c_vld = rv;
            m_rdy = ($urandom_range(0, 3) != 0);
            s_vld = 1'($urandom_range(0, 1));
            r_rdy = 2'($urandom_range(0, 3));
            s_rdata = $urandom;
            #1;
            g = -1;
            if (m_pend) g = m_pidx;
            else
                for (int k = 0; k < N; k++)
                    if (g < 0 && rv[(m_ptr + k) % N]) g = (m_ptr + k) % N;
            e_ovld = (g >= 0) && (m_q.size() < DP);
            e_irdy = (e_ovld && m_rdy) ? (2'b01 << g) : 2'b00;
            e_rspv = (m_q.size() > 0 && s_vld) ? (2'b01 << m_q[0]) : 2'b00;
            e_ordy = (m_q.size() > 0) && r_rdy[m_q[0]];
            chk("rnd_ovld", 64'(m_vld), 64'(e_ovld));
            chk("rnd_irdy", 64'(c_rdy), 64'(e_irdy));
            chk("rnd_irspv", 64'(r_vld), 64'(e_rspv));
            chk("rnd_orsprdy", 64'(s_rdy), 64'(e_ordy));
            if (e_ovld) begin
                chk("rnd_addr", 64'(m_addr), 64'(c_addr[g*AW +: AW]));
                chk("rnd_read", 64'(m_read), 64'(c_read[g]));
            end
            if (s_vld && e_ordy) void'(m_q.pop_front());
            if (e_ovld && m_rdy) begin
                m_q.push_back(g);
                m_ptr = (g + 1) % N;
                rv[g] = 1'b0;
            end
            m_pend = e_ovld && !m_rdy;
            m_pidx = g;
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
